// File: rtl/tile_pkg.sv
// Shared types and helpers for the tile array interface (writer and reader ends).
package tile_pkg;

    localparam int TILE_ROWS   = 8;
    localparam int TILE_COLS   = 16;
    localparam int TILE_DATA_W = 8;
    // Wide enough to hold ROWS*COLS at the 256x256 maximum.
    localparam int LEN_W       = 17;

    typedef logic [TILE_DATA_W-1:0] elem_t;
    typedef elem_t tile_t [0:TILE_ROWS-1][0:TILE_COLS-1];

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

    // A zero or oversized request means "the whole tile".
    function automatic logic [LEN_W-1:0] clip_len(input logic [15:0] len,
                                                  input logic [LEN_W-1:0] total);
        logic [LEN_W-1:0] l;
        l = {1'b0, len};
        if ((l == '0) || (l > total)) begin
            return total;
        end
        return l;
    endfunction

endpackage

// File: rtl/tile_rc_counter.sv
// Row/column wrap counter for walking a tile in row-major order; shared with the deserializer.
module tile_rc_counter
    import tile_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 16,
    parameter int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [ROW_W-1:0] row_nxt_o,
    output logic [COL_W-1:0] col_nxt_o,
    output logic             last_o
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_wrap;
    logic             row_wrap;

    always_comb begin
        col_wrap  = (col_q == COL_W'(COLS - 1));
        row_wrap  = (row_q == ROW_W'(ROWS - 1));
        last_o    = col_wrap && row_wrap;
        col_nxt_o = col_wrap ? '0 : col_q + COL_W'(1);
        row_nxt_o = row_q;
        if (col_wrap) begin
            row_nxt_o = row_wrap ? '0 : row_q + ROW_W'(1);
        end

        row_d = row_q;
        col_d = col_q;
        if (clr_i) begin
            row_d = '0;
            col_d = '0;
        end else if (en_i) begin
            row_d = row_nxt_o;
            col_d = col_nxt_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/tile_serializer.sv
// Captures a whole tile in one cycle and drains it row-major as a byte valid/ready stream.
// Optional TILE_SERIALIZER_LAST_EN adds byte_last_o / row_last_o framing outputs.
module tile_serializer
    import tile_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tile_i [0:ROWS-1][0:COLS-1],
    input  logic [15:0]       tile_len_i,
    input  logic              tile_valid_i,
    output logic              tile_ready_o,
    output logic [DATA_W-1:0] byte_o,
    output logic              byte_valid_o,
    input  logic              byte_ready_i,
    output logic              busy_o,
    output logic              done_o
`ifdef TILE_SERIALIZER_LAST_EN
    ,
    output logic              byte_last_o,
    output logic              row_last_o
`endif
);

    localparam int TOTAL = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [LEN_W-1:0] TOTAL_L = LEN_W'(TOTAL);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] buf_q [0:ROWS-1][0:COLS-1];
    logic [DATA_W-1:0] buf_d [0:ROWS-1][0:COLS-1];
    logic [LEN_W-1:0]  len_q, len_d;
    logic [15:0]       sent_q, sent_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic              vld_q, vld_d;
    logic              done_q, done_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [ROW_W-1:0]  row_nxt;
    logic [COL_W-1:0]  col_nxt;
    logic              pos_last;
    logic              xfer;
    logic              last_xfer;
    logic [LEN_W-1:0]  len_clip;

`ifdef TILE_SERIALIZER_LAST_EN
    logic              blast_q, blast_d;
    logic              rlast_q, rlast_d;
`endif

    tile_rc_counter #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_rc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .row_nxt_o (row_nxt),
        .col_nxt_o (col_nxt),
        .last_o    (pos_last)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        len_d    = len_q;
        sent_d   = sent_q;
        byte_d   = byte_q;
        vld_d    = vld_q;
        done_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        len_clip = clip_len(tile_len_i, TOTAL_L);
        xfer     = vld_q && byte_ready_i;
        // The position check keeps the walk inside the tile even if len_q were ever corrupt.
        last_xfer = xfer && (({1'b0, sent_q} == (len_q - LEN_W'(1))) || pos_last);
`ifdef TILE_SERIALIZER_LAST_EN
        blast_d  = blast_q;
        rlast_d  = rlast_q;
`endif

        case (state_q)
            IDLE: begin
                if (tile_valid_i) begin
                    buf_d   = tile_i;
                    len_d   = len_clip;
                    sent_d  = '0;
                    cnt_clr = 1'b1;
                    byte_d  = tile_i[0][0];
                    vld_d   = 1'b1;
                    state_d = SEND;
`ifdef TILE_SERIALIZER_LAST_EN
                    blast_d = (len_clip == LEN_W'(1));
                    rlast_d = (COLS == 1) || (len_clip == LEN_W'(1));
`endif
                end
            end
            SEND: begin
                if (last_xfer) begin
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (xfer) begin
                    sent_d = sent_q + 16'd1;
                    cnt_en = 1'b1;
                    byte_d = buf_q[row_nxt][col_nxt];
`ifdef TILE_SERIALIZER_LAST_EN
                    blast_d = (({1'b0, sent_q} + LEN_W'(2)) == len_q);
                    rlast_d = (col_nxt == COL_W'(COLS - 1)) ||
                              (({1'b0, sent_q} + LEN_W'(2)) == len_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            sent_q  <= '0;
            byte_q  <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef TILE_SERIALIZER_LAST_EN
            blast_q <= 1'b0;
            rlast_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sent_q  <= sent_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
`ifdef TILE_SERIALIZER_LAST_EN
            blast_q <= blast_d;
            rlast_q <= rlast_d;
`endif
        end
    end

    // Tile storage is pure data and is intentionally left out of reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign tile_ready_o = (state_q == IDLE);
    assign busy_o       = (state_q == SEND);
    assign byte_o       = byte_q;
    assign byte_valid_o = vld_q;
    assign done_o       = done_q;
`ifdef TILE_SERIALIZER_LAST_EN
    assign byte_last_o  = blast_q;
    assign row_last_o   = rlast_q;
`endif

endmodule

// File: tb/tb_tile_serializer.sv
// Scoreboard bench for tile_serializer: expected stream queued at drive time, popped on each transfer.
module tb_tile_serializer;

    localparam int ROWS  = 8;
    localparam int COLS  = 16;
    localparam int TOTAL = ROWS * COLS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tile [0:ROWS-1][0:COLS-1];
    logic [15:0] tile_len;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;
`ifdef TILE_SERIALIZER_LAST_EN
    logic        byte_last;
    logic        row_last;
`endif

    tile_serializer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tile_i       (tile),
        .tile_len_i   (tile_len),
        .tile_valid_i (tile_valid),
        .tile_ready_o (tile_ready),
        .byte_o       (byte_out),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready),
        .busy_o       (busy),
        .done_o       (done)
`ifdef TILE_SERIALIZER_LAST_EN
        ,
        .byte_last_o  (byte_last),
        .row_last_o   (row_last)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       rlast;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   xfer_cnt = 0;
    int   ncyc = 0;
    int   prev_cyc = 0;
    int   last_cyc = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    logic exp_done = 1'b0;
    logic stall_prev = 1'b0;
    logic have_prev = 1'b0;
    logic first_of_tile = 1'b0;
    logic [7:0] held_byte = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready pattern, updated just after each rising edge.
    initial begin
        byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: transfers happen at the next rising edge, so sample on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (!rst_n) begin
            exp_done      = 1'b0;
            stall_prev    = 1'b0;
            have_prev     = 1'b0;
            first_of_tile = 1'b0;
        end else begin
            check("done_o", 32'(done), 32'(exp_done));
            exp_done = 1'b0;
            check("ready_vs_busy", 32'(tile_ready), 32'(!busy));
            if (stall_prev) begin
                check("stall_valid", 32'(byte_valid), 32'd1);
                check("stall_byte", 32'(byte_out), 32'(held_byte));
            end
            stall_prev = 1'b0;
            if (byte_valid && byte_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", 32'(byte_out), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("byte_o", 32'(byte_out), 32'(e.d));
`ifdef TILE_SERIALIZER_LAST_EN
                    check("byte_last", 32'(byte_last), 32'(e.last));
                    check("row_last", 32'(row_last), 32'(e.rlast));
`endif
                    if (first_of_tile) begin
                        check("tile_gap_ok", 32'((ncyc - last_cyc) >= 2), 32'd1);
                        first_of_tile = 1'b0;
                    end else if (have_prev && ready_mode == 0) begin
                        check("consecutive", 32'(ncyc - prev_cyc), 32'd1);
                    end
                    have_prev = 1'b1;
                    prev_cyc  = ncyc;
                    xfer_cnt++;
                    if (e.last) begin
                        exp_done      = 1'b1;
                        first_of_tile = 1'b1;
                        have_prev     = 1'b0;
                        last_cyc      = ncyc;
                    end
                end
            end else if (byte_valid) begin
                stall_prev = 1'b1;
                held_byte  = byte_out;
            end
        end
    end

    task automatic send_tile(input int len_in, input int off);
        int   n;
        logic acc;
        exp_t e;
        acc = 1'b0;
        n = (len_in == 0 || len_in > TOTAL) ? TOTAL : len_in;
        @(posedge clk);
        #1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tile[r][c] = 8'(r * COLS + c + off);
        for (int i = 0; i < n; i++) begin
            e.d     = 8'(i + off);
            e.last  = (i == n - 1);
            e.rlast = ((i % COLS) == COLS - 1) || (i == n - 1);
            sb.push_back(e);
        end
        tile_len   = 16'(len_in);
        tile_valid = 1'b1;
        for (int k = 0; k < 3000 && !acc; k++) begin
            @(negedge clk);
            if (tile_ready) begin
                acc = 1'b1;
                @(posedge clk);
                #1;
                tile_valid = 1'b0;
            end
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            tile_valid = 1'b0;
        end else begin
            @(negedge clk);
            check("first_valid", 32'(byte_valid), 32'd1);
            check("busy_after_accept", 32'(busy), 32'd1);
            check("not_ready_in_send", 32'(tile_ready), 32'd0);
        end
    endtask

    task automatic drain();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 5000 && !ok; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && tile_ready) ok = 1'b1;
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        logic hit;
        tile_valid = 1'b0;
        tile_len   = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                tile[r][c] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_tile_ready", 32'(tile_ready), 32'd1);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_byte_o", 32'(byte_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Full tile, ready always high, length 0 meaning whole tile.
        ready_mode = 0;
        base = xfer_cnt;
        send_tile(0, 0);
        drain();
        check("full_count", 32'(xfer_cnt - base), 32'd128);

        // Backpressure 1,0,0,1.
        ready_mode = 1;
        base = xfer_cnt;
        send_tile(0, 8'h20);
        drain();
        check("bp_count", 32'(xfer_cnt - base), 32'd128);

        // Length clipping cases.
        ready_mode = 0;
        base = xfer_cnt;
        send_tile(20, 0);
        drain();
        check("len20_count", 32'(xfer_cnt - base), 32'd20);
        base = xfer_cnt;
        send_tile(1, 8'h80);
        drain();
        check("len1_count", 32'(xfer_cnt - base), 32'd1);
        base = xfer_cnt;
        send_tile(300, 7);
        drain();
        check("len300_count", 32'(xfer_cnt - base), 32'd128);

        // Second tile held valid during SEND; random ready.
        ready_mode = 2;
        base = xfer_cnt;
        send_tile(0, 8'h10);
        send_tile(40, 8'h40);
        drain();
        check("b2b_count", 32'(xfer_cnt - base), 32'd168);

        // Reset at transfer 50.
        base = xfer_cnt;
        send_tile(0, 8'h55);
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            @(negedge clk);
            if (xfer_cnt >= base + 50) hit = 1'b1;
        end
        if (!hit) check("xfer50_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tile_ready", 32'(tile_ready), 32'd1);
        check("mid_rst_byte_valid", 32'(byte_valid), 32'd0);
        check("mid_rst_byte_o", 32'(byte_out), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            check("done_in_reset", 32'(done), 32'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        ready_mode = 0;
        base = xfer_cnt;
        send_tile(0, 8'h33);
        drain();
        check("post_rst_count", 32'(xfer_cnt - base), 32'd128);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tile_serializer.md
Name: tile_serializer

Overview:
- Drains an 8x16 byte tile, in the array shape that the team's tile-processing modules produce, into a single-byte valid/ready stream.
- It is the reader end of the tile array interface: it captures a whole tile in one cycle, then emits its elements in row-major order.
- It sits between a tile-producing compute stage and a narrow downstream link or buffer.

Parameters:
- ROWS, 8, tile row count (1..256)
- COLS, 16, tile column count (1..256)
- DATA_W, 8, element width in bits
- localparam TOTAL, ROWS*COLS, elements per tile

Ports:
- clk  input  1  clock
- rst_n  input  1  async active-low reset
- tile_i  input  DATA_W x [0:ROWS-1][0:COLS-1]  unpacked tile array
- tile_len_i  input  16  element count to send; 0 or >TOTAL means TOTAL
- tile_valid_i  input  1  tile_i/tile_len_i valid
- tile_ready_o  output  1  block can accept a tile
- byte_o  output  DATA_W  current stream element
- byte_valid_o  output  1  byte_o valid
- byte_ready_i  input  1  downstream accepts byte_o
- busy_o  output  1  tile held, not fully sent
- done_o  output  1  one-cycle pulse after last element accepted

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - tile_ready_o=1, byte_valid_o=0, byte_o=0, busy_o=0, done_o=0.
  - FSM=IDLE, row/col counters=0, sent counter=0.
  - The tile buffer is not reset.
- FSM states: IDLE, SEND.
- IDLE:
  - tile_ready_o=1.
  - On tile_valid_i & tile_ready_o: capture tile_i into the buffer and latch the clipped length into len_q.
  - Clear row, col and sent counters; go to SEND.
- SEND:
  - byte_valid_o=1 and byte_o=buf[row][col], registered.
  - First byte is valid the cycle after the tile is accepted (latency 1).
- Handshake:
  - A transfer occurs when byte_valid_o & byte_ready_i.
  - byte_o and byte_valid_o stay stable while byte_ready_i=0 (AXI-stream rules).
  - Stalls of any length are allowed.
- Per transfer:
  - sent += 1.
  - col += 1; when col wraps at COLS-1, col=0 and row += 1.
- Last transfer (sent==len_q-1):
  - byte_valid_o deasserts next cycle.
  - FSM returns to IDLE.
  - done_o pulses for exactly one cycle, the same cycle tile_ready_o returns to 1.
- No tile overlap: tile_ready_o=0 throughout SEND. A tile_valid_i asserted during SEND is ignored and must be held by the producer.
- busy_o=1 exactly while in SEND.
- Length clipping: len_q = (tile_len_i==0 || tile_len_i>TOTAL) ? TOTAL : tile_len_i. len_q=1 sends only buf[0][0].
- Back-to-back tiles: minimum gap is one idle cycle between the last transfer and the next tile accept.
- Counter widths: row is clog2(ROWS), col is clog2(COLS) (min 1 bit each), sent is 16 bits. Counters do not wrap beyond len_q.
- Reset mid-SEND: all state returns to the reset values immediately. The partial tile is discarded and done_o is not pulsed.
- byte_o holds its last value when byte_valid_o=0.

Optional Feature:
- Macro: TILE_SERIALIZER_LAST_EN.
- When defined, two extra outputs are present:
  - byte_last_o (1): high with the final element of the tile.
  - row_last_o (1): high with col==COLS-1, or with the final element.
  - Both follow the same valid/stability rules as byte_o and reset to 0.
- When undefined, neither port exists and the logic is removed. All other behaviour is identical.

Decomposition:
- Shared package tile_pkg holds:
  - TILE_ROWS=8, TILE_COLS=16, TILE_DATA_W=8.
  - typedef elem_t (logic [7:0]).
  - typedef tile_t (elem_t [0:7][0:15] unpacked).
  - typedef enum ser_state_e {IDLE, SEND}.
  - function clip_len().
- One natural sub-module: tile_rc_counter, a row/col wrap counter with enable, clear and last flag. It is reusable by the matching deserializer.

Test Plan:
- Full tile, byte_ready_i=1 always, tile_len_i=0, buf[r][c]=r*16+c:
  - bytes 0x00..0x7F appear on 128 consecutive cycles starting 1 cycle after accept.
  - done_o pulses the cycle after 0x7F is accepted.
- Backpressure, byte_ready_i toggling 1,0,0,1 pattern:
  - byte_o is stable across stalls and no element is skipped or duplicated.
  - Total transfers = 128.
- Length clipping:
  - tile_len_i=20 sends 0x00..0x13 and wraps row after 0x0F.
  - tile_len_i=1 sends only 0x00.
  - tile_len_i=300 sends 128 elements.
- tile_valid_i held high with a second tile during SEND:
  - the second tile is ignored until tile_ready_o=1.
  - Its first byte appears after ≥1 idle cycle.
- rst_n asserted low at transfer 50, then released:
  - outputs take reset values asynchronously and done_o is never pulsed.
  - A new tile then sends from element 0.
- With TILE_SERIALIZER_LAST_EN:
  - row_last_o is high on elements 15, 31, …, 127.
  - byte_last_o is high only on element 127 (or element 19 when tile_len_i=20).
